// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: owns the GRF write port, merging W-stage write-back (always wins)
// with a FIFO-buffered secondary source, and tracks pending secondary writes in a busy scoreboard.
`default_nettype none

module grf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iW_WE,
  input  logic [4:0]               iW_Addr,
  input  logic [31:0]              iW_Data,
  input  logic [31:0]              iW_PC8,
  input  logic                     iS_Valid,
  input  logic [4:0]               iS_Addr,
  input  logic [31:0]              iS_Data,
  input  logic [31:0]              iS_PC8,
  output logic                     oS_Ready,
  input  logic                     iRes_Valid,
  input  logic [4:0]               iRes_Addr,
  output logic [4:0]               oA3_Addr,
  output logic [31:0]              oWD,
  output logic                     oWE,
  output logic [31:0]              oPC8,
  output logic [31:0]              oBusy,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc8  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_next;

  logic prim_wr;
  logic push;
  logic pop;

  assign oS_Ready = (count != FULL_COUNT);
  assign oCount   = count;
  assign oBusy    = busy;

  // A write to $0 is a no-op on either source, so it never enters the FIFO
  // and never shadows a pending pop.
  assign prim_wr = iW_WE && (iW_Addr != 5'd0);
  assign push    = iS_Valid && oS_Ready && (iS_Addr != 5'd0);
  assign pop     = !prim_wr && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= iS_Addr;
      fifo_data[tail] <= iS_Data;
      fifo_pc8[tail]  <= iS_PC8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oWE      <= 1'b0;
      oA3_Addr <= 5'd0;
      oWD      <= 32'd0;
      oPC8     <= 32'd0;
    end else if (prim_wr) begin
      oWE      <= 1'b1;
      oA3_Addr <= iW_Addr;
      oWD      <= iW_Data;
      oPC8     <= iW_PC8;
    end else if (pop) begin
      oWE      <= 1'b1;
      oA3_Addr <= fifo_addr[head];
      oWD      <= fifo_data[head];
      oPC8     <= fifo_pc8[head];
    end else begin
      oWE      <= 1'b0;
    end
  end

  // Clear applies first so a same-edge reservation of the popped register survives.
  always_comb begin
    busy_next = busy;
    if (pop) begin
      busy_next = busy_next & ~(32'd1 << fifo_addr[head]);
    end
    if (iRes_Valid && (iRes_Addr != 5'd0)) begin
      busy_next = busy_next | (32'd1 << iRes_Addr);
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: directed stimulus queues expected GRF writes, a negedge monitor checks them.
`default_nettype none

module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iW_WE;
  logic [4:0]  iW_Addr;
  logic [31:0] iW_Data;
  logic [31:0] iW_PC8;
  logic        iS_Valid;
  logic [4:0]  iS_Addr;
  logic [31:0] iS_Data;
  logic [31:0] iS_PC8;
  logic        oS_Ready;
  logic        iRes_Valid;
  logic [4:0]  iRes_Addr;
  logic [4:0]  oA3_Addr;
  logic [31:0] oWD;
  logic        oWE;
  logic [31:0] oPC8;
  logic [31:0] oBusy;
  logic [2:0]  oCount;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc8;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  grf_wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .iW_WE(iW_WE), .iW_Addr(iW_Addr), .iW_Data(iW_Data), .iW_PC8(iW_PC8),
    .iS_Valid(iS_Valid), .iS_Addr(iS_Addr), .iS_Data(iS_Data), .iS_PC8(iS_PC8),
    .oS_Ready(oS_Ready),
    .iRes_Valid(iRes_Valid), .iRes_Addr(iRes_Addr),
    .oA3_Addr(oA3_Addr), .oWD(oWD), .oWE(oWE), .oPC8(oPC8),
    .oBusy(oBusy), .oCount(oCount)
  );

  always #5 clk = ~clk;

  // Monitor: every GRF write must match the next expected write in order.
  always @(negedge clk) begin
    if (oWE) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h pc8=%h, required no write",
                 oA3_Addr, oWD, oPC8);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (oA3_Addr !== e.addr || oWD !== e.data || oPC8 !== e.pc8) begin
          fails++;
          $display("FAIL grf_write: got addr=%0d data=%h pc8=%h, required addr=%0d data=%h pc8=%h",
                   oA3_Addr, oWD, oPC8, e.addr, e.data, e.pc8);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.pc8  = p;
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    iW_WE = 1'b0; iW_Addr = 5'd0; iW_Data = 32'd0; iW_PC8 = 32'd0;
    iS_Valid = 1'b0; iS_Addr = 5'd0; iS_Data = 32'd0; iS_PC8 = 32'd0;
    iRes_Valid = 1'b0; iRes_Addr = 5'd0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("reset_oWE", 32'(oWE), 32'd0);
    check("reset_oBusy", oBusy, 32'd0);
    check("reset_oCount", 32'(oCount), 32'd0);
    check("reset_oS_Ready", 32'(oS_Ready), 32'd1);
    check("reset_oA3_oWD_oPC8", {27'd0, oA3_Addr} | oWD | oPC8, 32'd0);
    step();
    check("idle_oWE", 32'(oWE), 32'd0);

    // Primary only
    iW_WE = 1'b1; iW_Addr = 5'd5; iW_Data = 32'h12345678; iW_PC8 = 32'h3008;
    expect_wr(5'd5, 32'h12345678, 32'h3008);
    step();
    clear_inputs();
    check("prim_oWE", 32'(oWE), 32'd1);
    step();
    check("prim_oWE_after", 32'(oWE), 32'd0);
    check("prim_hold_addr", 32'(oA3_Addr), 32'd5);

    // Reserve then secondary write
    iRes_Valid = 1'b1; iRes_Addr = 5'd9;
    step();
    clear_inputs();
    check("res_busy9", oBusy, 32'h0000_0200);
    iS_Valid = 1'b1; iS_Addr = 5'd9; iS_Data = 32'hDEADBEEF; iS_PC8 = 32'h4000;
    expect_wr(5'd9, 32'hDEADBEEF, 32'h4000);
    step();
    clear_inputs();
    check("sec_push_count", 32'(oCount), 32'd1);
    check("sec_push_no_bypass", 32'(oWE), 32'd0);
    step();
    check("sec_pop_oWE", 32'(oWE), 32'd1);
    check("sec_pop_busy_clear", oBusy, 32'd0);
    check("sec_pop_count", 32'(oCount), 32'd0);

    // Priority and backpressure: primaries 1..6 every cycle, secondaries 10..14 offered
    for (int c = 0; c < 6; c++) begin
      iW_WE = 1'b1; iW_Addr = 5'(c + 1); iW_Data = 32'h100 + 32'(c); iW_PC8 = 32'h1000 + 32'(4 * c);
      expect_wr(5'(c + 1), 32'h100 + 32'(c), 32'h1000 + 32'(4 * c));
      iS_Valid = 1'b1;
      iS_Addr = (c < 4) ? 5'(10 + c) : 5'd14;
      iS_Data = 32'h200 + 32'(iS_Addr);
      iS_PC8  = 32'h2000 + 32'(iS_Addr);
      step();
    end
    clear_inputs();
    check("full_oS_Ready", 32'(oS_Ready), 32'd0);
    check("full_oCount", 32'(oCount), 32'd4);
    for (int r = 10; r < 14; r++) begin
      expect_wr(5'(r), 32'h200 + 32'(r), 32'h2000 + 32'(r));
    end
    step();
    check("first_pop_ready", 32'(oS_Ready), 32'd1);
    step();
    step();
    step();
    check("drain_count", 32'(oCount), 32'd0);
    step();
    check("drain_idle_oWE", 32'(oWE), 32'd0);

    // $0 handling: queue reg 7 behind a primary, then primary to $0 and a secondary push to $0
    iW_WE = 1'b1; iW_Addr = 5'd2; iW_Data = 32'h22; iW_PC8 = 32'h2208;
    iS_Valid = 1'b1; iS_Addr = 5'd7; iS_Data = 32'h777; iS_PC8 = 32'h7000;
    expect_wr(5'd2, 32'h22, 32'h2208);
    expect_wr(5'd7, 32'h777, 32'h7000);
    step();
    check("zero_q_count", 32'(oCount), 32'd1);
    iW_WE = 1'b1; iW_Addr = 5'd0; iW_Data = 32'hBAD0; iW_PC8 = 32'hBAD8;
    iS_Valid = 1'b1; iS_Addr = 5'd0; iS_Data = 32'hBAD1; iS_PC8 = 32'hBAD9;
    step();
    clear_inputs();
    check("zero_pop_addr", 32'(oA3_Addr), 32'd7);
    check("zero_push_count", 32'(oCount), 32'd0);
    step();
    check("zero_no_write", 32'(oWE), 32'd0);

    // Reset mid-queue with regs 7,8,9 queued and reserved
    for (int c = 0; c < 3; c++) begin
      iRes_Valid = 1'b1; iRes_Addr = 5'(7 + c);
      iW_WE = 1'b1; iW_Addr = 5'(3 + c); iW_Data = 32'h300 + 32'(c); iW_PC8 = 32'h3300 + 32'(c);
      expect_wr(5'(3 + c), 32'h300 + 32'(c), 32'h3300 + 32'(c));
      iS_Valid = 1'b1; iS_Addr = 5'(7 + c); iS_Data = 32'hABC0 + 32'(c); iS_PC8 = 32'hC000 + 32'(c);
      step();
    end
    clear_inputs();
    check("pre_reset_count", 32'(oCount), 32'd3);
    check("pre_reset_busy", oBusy, 32'h0000_0380);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_count", 32'(oCount), 32'd0);
    check("mid_reset_busy", oBusy, 32'd0);
    check("mid_reset_oWE", 32'(oWE), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("post_reset_no_write", 32'(oWE), 32'd0);
    end

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-back arbiter that owns the single GRF write port. It merges two write sources: the pipeline W-stage write-back, which always wins, and a long-latency secondary source such as the multiply/divide unit, which is buffered in a small FIFO. It presents one registered write per cycle to the GRF write port (A3 address, write data, write enable, PC+8). It also keeps a 32-bit busy scoreboard of registers with outstanding secondary writes, which the decoder uses to stall dependent reads.

## Interface
- DEPTH, 4, secondary FIFO depth; power of two, ≥2
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- iW_WE  in  1  primary (W-stage) write valid; never back-pressured
- iW_Addr  in  5  primary destination register
- iW_Data  in  32  primary write data
- iW_PC8  in  32  PC+8 of the primary instruction
- iS_Valid  in  1  secondary write request
- iS_Addr  in  5  secondary destination register
- iS_Data  in  32  secondary write data
- iS_PC8  in  32  PC+8 of the secondary instruction
- oS_Ready  out  1  secondary accept; equals FIFO not full; combinational from count
- iRes_Valid  in  1  reserve a register for a future secondary write, asserted at issue
- iRes_Addr  in  5  register to reserve
- oA3_Addr  out  5  GRF write address, registered
- oWD  out  32  GRF write data, registered
- oWE  out  1  GRF write enable, registered
- oPC8  out  32  PC+8 forwarded to the GRF for trace, registered
- oBusy  out  32  bit r set means register r has a pending secondary write; bit 0 always 0
- oCount  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset, sampled on a clk edge: FIFO empty, oCount=0, oBusy=0, oWE=0, oA3_Addr=0, oWD=0, oPC8=0, oS_Ready=1.
- Push: on a clk edge where iS_Valid && oS_Ready:
  - iS_Addr≠0: the entry is enqueued at the tail.
  - iS_Addr=0: the handshake completes, nothing is enqueued, occupancy is unchanged.
  - iS_Valid while full: not accepted; the source holds the request.
- Output selection each edge, in priority order:
  1. iW_WE && iW_Addr≠0: register the primary write, oWE=1.
  2. Else, FIFO non-empty: pop the head, register it, oWE=1.
  3. Else: oWE=0. oA3_Addr, oWD and oPC8 keep their last values.
- A primary write to $0 is dropped and counts as no primary, so a pending FIFO entry may pop in that cycle.
- No same-cycle bypass: an entry pushed at edge k cannot pop before edge k+1.
- A push and a pop in the same edge leave occupancy unchanged. This is legal even when full, but oS_Ready is computed from the pre-edge count, so a push into a full FIFO is never accepted.
- Pointers wrap modulo DEPTH. oCount ranges 0..DEPTH.
- Scoreboard:
  - Set: iRes_Valid && iRes_Addr≠0 sets oBusy[iRes_Addr].
  - Clear: a pop of register r clears oBusy[r] on the same edge oWE rises for it.
  - Same-edge set and clear of the same bit: set wins.
  - Reserving an already-busy register is a decoder error. The bit clears on the first pop for that register.
- Primary writes never touch oBusy.
- WAW ordering between a primary and a pending secondary write to the same register is the decoder's responsibility; it stalls on oBusy. The arbiter applies writes in the order they reach its output.
- Starvation: the secondary source may starve while the primary writes every cycle. This is by design, since pipeline bubbles drain the FIFO.

## Timing
- Primary latency: inputs sampled at edge k, GRF write committed at edge k+1.
- Secondary latency: accepted at edge k; earliest oWE at edge k+1; GRF commit at edge k+2.
- Outputs are held stable for the whole cycle, so the GRF internal bypass sees a clean oWE/oA3_Addr/oWD.
- A reset asserted mid-operation discards all queued entries and busy bits at that edge. oWE=0 during the following cycle.
- oS_Ready falls in the cycle after the edge that makes the FIFO full. It rises in the cycle after the first pop from full.

## Test plan
- Reset, then idle:
  - Required: oWE=0, oBusy=0, oCount=0, oS_Ready=1.
- Primary only: iW_WE=1, iW_Addr=5, iW_Data=0x12345678, iW_PC8=0x3008 for one cycle.
  - Required: next cycle oWE=1, oA3_Addr=5, oWD=0x12345678, oPC8=0x3008; the cycle after, oWE=0.
- Reserve and secondary write: iRes_Valid with addr 9, then push (9, 0xDEADBEEF) with no primary.
  - Required: oBusy[9]=1 after the reserve; oWE=1 with oA3_Addr=9 one cycle after the push; oBusy[9]=0 in that same cycle.
- Priority and backpressure:
  - Stimulus: primary writes every cycle to regs 1..6 while DEPTH+1 secondary pushes (regs 10..14) are offered.
  - Required: only 4 are accepted; oS_Ready=0 and oCount=4; all primaries appear in order; after iW_WE drops, regs 10..13 drain one per cycle.
- $0 handling:
  - Stimulus: primary to $0 while one entry (reg 7) is queued; also a secondary push to $0.
  - Required: reg 7 pops in the same cycle; the $0 push does not change oCount and never produces oWE.
- Reset mid-queue with 3 entries queued and oBusy=0x00000380:
  - Required: next cycle oCount=0, oBusy=0, oWE=0; no queued entry is ever written.
